alu_seq_ctrl: RTL

Single-button, sequenced operand-entry controller with an integrated registered ALU, for the Basys 3 switch/LED flow. It replaces the three-button A/B/Op latch scheme. One debounced "next" button steps an FSM through A, B and Op capture, one execute cycle, and a result-display state. It is parametrised in operand width, opcode width, switch count and debounce length, and adds a result-valid handshake, an invalid-op flag, and defined out-of-range shift behaviour.

---
 rtl/alu_seq_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Single-button operand-entry controller with a registered ALU.
//   A debounced "next" button steps the sequence:
//     S_A -> S_B -> S_OP -> S_EXEC -> S_RES -> S_A
//   Operands and the opcode are captured from the switches one step at a time.
//   S_EXEC registers the ALU result and its flags, and S_RES presents them with
//   o_valid high.
//
// Ports
//   i_clock   system clock
//   i_reset   synchronous, active-high reset
//   i_sw      raw switches (A/B use [N-1:0], the opcode uses [NSel-1:0])
//   i_next    raw, asynchronous, bouncy "next" button
//   o_alu_A   latched operand A
//   o_alu_B   latched operand B
//   o_alu_Op  latched opcode
//   o_result  registered ALU result
//   o_ovf     signed overflow (ADD/SUB only)
//   o_zero    result == 0
//   o_op_err  unsupported opcode
//   o_valid   high only while in S_RES
//   o_state   current FSM state
//   o_led     {o_ovf, o_zero, o_op_err, zero pad, o_result}
module alu_seq_ctrl #(
  parameter int N         = 8,
  parameter int NSel      = 6,
  parameter int N_SW      = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [N_SW-1:0] i_sw,
  input  logic            i_next,
  output logic [N-1:0]    o_alu_A,
  output logic [N-1:0]    o_alu_B,
  output logic [NSel-1:0] o_alu_Op,
  output logic [N-1:0]    o_result,
  output logic            o_ovf,
  output logic            o_zero,
  output logic            o_op_err,
  output logic            o_valid,
  output logic [2:0]      o_state,
  output logic [N_SW-1:0] o_led
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;

  localparam logic [NSel-1:0] OP_ADD = NSel'(6'b100000);
  localparam logic [NSel-1:0] OP_SUB = NSel'(6'b100010);
  localparam logic [NSel-1:0] OP_AND = NSel'(6'b100100);
  localparam logic [NSel-1:0] OP_OR  = NSel'(6'b100101);
  localparam logic [NSel-1:0] OP_XOR = NSel'(6'b100110);
  localparam logic [NSel-1:0] OP_NOR = NSel'(6'b100111);
  localparam logic [NSel-1:0] OP_SRL = NSel'(6'b000010);
  localparam logic [NSel-1:0] OP_SRA = NSel'(6'b000011);

  localparam int            CNT_W     = $clog2(DB_CYCLES + 1);
  localparam logic [N-1:0]  SHIFT_LIM = N'(N);

  // Button conditioning
  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             next_pulse_reg;
  logic [CNT_W-1:0] db_cnt_reg;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      stable_reg     <= 1'b0;
      next_pulse_reg <= 1'b0;
      db_cnt_reg     <= '0;
    end else begin
      sync1_reg      <= i_next;
      sync2_reg      <= sync1_reg;
      next_pulse_reg <= 1'b0;
      if (sync2_reg != stable_reg) begin
        // The edge that brings the count to DB_CYCLES also commits the
        // new level, so the pulse register is loaded on that same edge.
        if (db_cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
          stable_reg     <= sync2_reg;
          db_cnt_reg     <= '0;
          next_pulse_reg <= sync2_reg;
        end else begin
          db_cnt_reg <= db_cnt_reg + CNT_W'(1);
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  // Datapath registers
  logic [2:0]      state_reg;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic [NSel-1:0] op_reg;
  logic [N-1:0]    result_reg;
  logic            ovf_reg;
  logic            zero_reg;
  logic            op_err_reg;

  // ALU (combinational, sampled in S_EXEC)
  logic [N-1:0] alu_res;
  logic         alu_ovf;
  logic         alu_err;
  logic [N-1:0] sum;
  logic [N-1:0] diff;
  logic         shift_big;

  assign sum       = a_reg + b_reg;
  assign diff      = a_reg - b_reg;
  assign shift_big = (b_reg >= SHIFT_LIM);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_reg[N-1] == b_reg[N-1]) && (sum[N-1] != a_reg[N-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_reg[N-1] != b_reg[N-1]) && (diff[N-1] != a_reg[N-1]);
      end
      OP_AND: alu_res = a_reg & b_reg;
      OP_OR:  alu_res = a_reg | b_reg;
      OP_XOR: alu_res = a_reg ^ b_reg;
      OP_NOR: alu_res = ~(a_reg | b_reg);
      // Shift amounts of N or more saturate: zero for logical, sign fill
      // for arithmetic.
      OP_SRL: alu_res = shift_big ? '0 : (a_reg >> b_reg);
      OP_SRA: alu_res = shift_big ? {N{a_reg[N-1]}}
                                  : N'($signed(a_reg) >>> b_reg);
      default: alu_err = 1'b1;
    endcase
  end

  // Sequencing FSM
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg  <= S_A;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      op_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_A: if (next_pulse_reg) begin
          a_reg     <= i_sw[N-1:0];
          state_reg <= S_B;
        end
        S_B: if (next_pulse_reg) begin
          b_reg     <= i_sw[N-1:0];
          state_reg <= S_OP;
        end
        S_OP: if (next_pulse_reg) begin
          op_reg    <= i_sw[NSel-1:0];
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          result_reg <= alu_res;
          ovf_reg    <= alu_ovf;
          zero_reg   <= (alu_res == '0);
          op_err_reg <= alu_err;
          state_reg  <= S_RES;
        end
        S_RES: if (next_pulse_reg) begin
          state_reg <= S_A;
        end
        default: state_reg <= S_A;
      endcase
    end
  end

  assign o_alu_A  = a_reg;
  assign o_alu_B  = b_reg;
  assign o_alu_Op = op_reg;
  assign o_result = result_reg;
  assign o_ovf    = ovf_reg;
  assign o_zero   = zero_reg;
  assign o_op_err = op_err_reg;
  assign o_valid  = (state_reg == S_RES);
  assign o_state  = state_reg;

  // LED map: result in the low bits, flags in the top three, zeros between.
  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_led
      if (gi < N) begin : g_res
        assign o_led[gi] = result_reg[gi];
      end else if (gi == N_SW - 1) begin : g_ovf
        assign o_led[gi] = ovf_reg;
      end else if (gi == N_SW - 2) begin : g_zero
        assign o_led[gi] = zero_reg;
      end else if (gi == N_SW - 3) begin : g_err
        assign o_led[gi] = op_err_reg;
      end else begin : g_pad
        assign o_led[gi] = 1'b0;
      end
    end
  endgenerate

  // Switch bits above the operand/opcode fields are not used.
  logic unused_sw;
  assign unused_sw = ^i_sw;

endmodule
